// File: rtl/path_reader_if.sv
// rtl/path_reader_if.sv - stream bundle between the path list, path_reader and the move stage
//
// Purpose: groups the list readback stream (request, items, end marker) and
// the downstream valid/ready item stream into one bundle.
// Signals:
//   en_read    one-cycle read request towards the path list
//   in_valid   in_data carries an item this cycle
//   in_data    WIDTH-bit direction code, last-pushed first
//   in_done    one-cycle end-of-stream marker
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data
//   out_data   WIDTH-bit direction code towards the move stage
// Modports: slave = path_reader side, master = list/downstream side.

interface path_reader_if #(
    parameter int WIDTH = 2
);
    logic             en_read;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_done;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        output en_read,
        input  in_valid,
        input  in_data,
        input  in_done,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport master (
        input  en_read,
        output in_valid,
        output in_data,
        output in_done,
        input  out_valid,
        output out_ready,
        input  out_data
    );
endinterface

// File: rtl/path_reader.sv
// rtl/path_reader.sv - consumer of the direction-list readback stream with an output FIFO
//
// Purpose: on start, requests a readback from the path list, captures the
// streamed direction codes into a small FIFO and re-presents them
// downstream on a valid/ready handshake, counting delivered items and
// flagging items dropped on a full FIFO.
// Ports:
//   CLK       clock, rising edge
//   RST       synchronous active-low reset
//   start     begin a readback (honoured only when idle)
//   bus       path_reader_if.slave: en_read, in_valid/in_data/in_done,
//             out_valid/out_ready/out_data
//   busy      high whenever not idle
//   done      one-cycle pulse once the readback has fully drained
//   count     items delivered downstream in the current or last readback
//   overflow  sticky, an item was dropped because the FIFO was full

module path_reader #(
    parameter int MAX_LENGTH = 256,
    parameter int WIDTH      = 2,
    parameter int DEPTH      = 4,
    localparam int CW        = $clog2(MAX_LENGTH) + 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    path_reader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    output logic          overflow
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic             en_read_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

    assign empty = (occ == '0);
    assign full  = (occ == (AW+1)'(DEPTH));
    assign pop   = !empty && bus.out_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push  = (state == STREAM) && bus.in_valid && (!full || pop);
    assign drop  = (state == STREAM) && bus.in_valid && full && !pop;

    assign bus.en_read   = en_read_q;
    assign bus.out_valid = !empty;
    assign bus.out_data  = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            en_read_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            en_read_q <= 1'b0;
            done      <= 1'b0;

            if (push) begin
                mem[wr_ptr] <= bus.in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (count != '1) begin
                    count <= count + 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end

            // State updates come last so the IDLE->REQ clear overrides FIFO activity.
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= REQ;
                        en_read_q <= 1'b1;
                        busy      <= 1'b1;
                        count     <= '0;
                        overflow  <= 1'b0;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        occ       <= '0;
                    end
                end
                REQ: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (bus.in_done) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_reader.sv
// tb/tb_path_reader.sv - scoreboard testbench for path_reader

module tb_path_reader;
    localparam int WIDTH      = 2;
    localparam int MAX_LENGTH = 256;
    localparam int DEPTH      = 4;
    localparam int CW         = 9;

    logic          CLK   = 1'b0;
    logic          RST   = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          overflow;

    path_reader_if #(.WIDTH(WIDTH)) bus();

    path_reader #(
        .MAX_LENGTH(MAX_LENGTH),
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .bus     (bus.slave),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_q[$];
    int done_cnt_q[$];
    int done_ovf_q[$];
    int en_pulses = 0;
    int mon_e;
    int en0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int d, input bit keep);
        bus.in_valid = 1'b1;
        bus.in_data  = d[WIDTH-1:0];
        if (keep) exp_q.push_back(d);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic begin_readback();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic finish_stream(input int exp_count, input int exp_ovf);
        done_cnt_q.push_back(exp_count);
        done_ovf_q.push_back(exp_ovf);
        bus.in_done = 1'b1;
        tick();
        bus.in_done = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !done; i++) tick();
        chk("done_seen", int'(done), 1);
        tick();
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over an item or pulses done.
    always @(negedge CLK) begin
        if (RST) begin
            if (bus.en_read) en_pulses++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_item", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", int'(bus.out_data), mon_e);
                end
            end
            if (done) begin
                if (done_cnt_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = done_cnt_q.pop_front();
                    chk("done_count", int'(count), mon_e);
                    mon_e = done_ovf_q.pop_front();
                    chk("done_overflow", int'(overflow), mon_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_done   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        RST = 1'b0;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_en_read", int'(bus.en_read), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        RST = 1'b1;
        tick();

        // 1: basic readback 3,1,2,0 with downstream always ready
        bus.out_ready = 1'b1;
        en0 = en_pulses;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_en_read_req", int'(bus.en_read), 1);
        chk("t1_busy", int'(busy), 1);
        tick();
        chk("t1_en_read_stream", int'(bus.en_read), 0);
        send(3, 1);
        send(1, 1);
        send(2, 1);
        send(0, 1);
        finish_stream(4, 0);
        wait_done();
        chk("t1_en_pulses", en_pulses - en0, 1);
        chk("t1_idle_busy", int'(busy), 0);

        // 2: downstream stalled, 6 items into a 4-deep FIFO
        bus.out_ready = 1'b0;
        begin_readback();
        send(0, 1);
        send(1, 1);
        send(2, 1);
        send(3, 1);
        chk("t2_no_overflow_yet", int'(overflow), 0);
        send(1, 0);
        send(2, 0);
        chk("t2_overflow", int'(overflow), 1);
        finish_stream(4, 1);
        bus.out_ready = 1'b1;
        wait_done();

        // 3: full FIFO with simultaneous push and pop
        bus.out_ready = 1'b0;
        begin_readback();
        send(1, 1);
        send(2, 1);
        send(3, 1);
        send(0, 1);
        bus.in_valid  = 1'b1;
        bus.in_data   = 2'd2;
        bus.out_ready = 1'b1;
        exp_q.push_back(2);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("t3_overflow", int'(overflow), 0);
        chk("t3_out_valid", int'(bus.out_valid), 1);
        finish_stream(5, 0);
        bus.out_ready = 1'b1;
        wait_done();

        // 4: empty list
        bus.out_ready = 1'b1;
        begin_readback();
        chk("t4_out_valid_stream", int'(bus.out_valid), 0);
        finish_stream(0, 0);
        chk("t4_done_early", int'(done), 0);
        chk("t4_out_valid_drain", int'(bus.out_valid), 0);
        tick();
        chk("t4_done", int'(done), 1);
        chk("t4_count", int'(count), 0);
        chk("t4_out_valid_done", int'(bus.out_valid), 0);
        tick();

        // 5: reset mid-stream, then a clean readback
        bus.out_ready = 1'b1;
        begin_readback();
        send(2, 1);
        send(1, 1);
        chk("t5_count_before_rst", int'(count), 1);
        RST = 1'b0;
        tick();
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_out_valid", int'(bus.out_valid), 0);
        chk("t5_rst_count", int'(count), 0);
        exp_q.delete();
        RST = 1'b1;
        tick();
        en0 = en_pulses;
        begin_readback();
        send(1, 1);
        send(3, 1);
        finish_stream(2, 0);
        wait_done();
        chk("t5_en_pulses", en_pulses - en0, 1);

        // 6: start during STREAM ignored; last item arrives with in_done
        bus.out_ready = 1'b1;
        en0 = en_pulses;
        begin_readback();
        bus.in_valid = 1'b1;
        bus.in_data  = 2'd2;
        exp_q.push_back(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.in_data = 2'd1;
        exp_q.push_back(1);
        done_cnt_q.push_back(2);
        done_ovf_q.push_back(0);
        bus.in_done = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_done  = 1'b0;
        wait_done();
        chk("t6_en_pulses", en_pulses - en0, 1);

        repeat (3) tick();
        chk("leftover_items", exp_q.size(), 0);
        chk("leftover_done", done_cnt_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/path_reader.md
Name: path_reader

Overview:
- Consumer end of the direction-list readback stream. On `start`, it issues a one-cycle read request to the list and captures the reversed stream of WIDTH-bit direction codes.
- Captured codes go into an internal FIFO and are re-presented downstream on a valid/ready handshake.
- Counts the delivered items and flags overflow.
- Sits between the path list and the move/output stage of the maze solver.

Parameters:
- MAX_LENGTH, 256: maximum items per readback; sets counter width CW = BITS(MAX_LENGTH)+1 (9 at default).
- WIDTH, 2: direction code width.
- DEPTH, 4: internal FIFO depth; power of two, at least 2.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-low reset; sampled on the CLK rising edge.
- start  in  1  begin a readback; one-cycle pulse, honoured only in IDLE.
- en_read  out  1  read request to the list; one-cycle pulse.
- in_valid  in  1  in_data holds a valid item this cycle.
- in_data  in  WIDTH  streamed item, last-pushed first.
- in_done  in  1  end of stream; one-cycle pulse.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  FIFO head.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the readback has fully drained.
- count  out  CW  items delivered downstream in the current or last readback.
- overflow  out  1  sticky; an item was dropped because the FIFO was full.

Behaviour:
- Reset (RST low at the edge):
  - State goes to IDLE.
  - FIFO is emptied.
  - en_read, out_valid, busy, done, overflow and count are all 0.
  - out_data is 0.
  - Reset wins over every other input, including mid-stream; a partially received stream is discarded.
- State machine:
  - IDLE: on start go to REQ, clear count and overflow, empty the FIFO. start with in_valid/in_done in IDLE: in_valid and in_done are ignored.
  - REQ: en_read is 1 for exactly this cycle. Unconditionally go to STREAM.
  - STREAM: each cycle with in_valid=1, write in_data into the FIFO. On in_done go to DRAIN. If in_valid and in_done arrive in the same cycle, the item is written first, then the transition happens.
  - DRAIN: no writes accepted; any in_valid here is ignored. When the FIFO is empty, go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE. count holds its value until the next start.
- start outside IDLE is ignored and does not restart the readback.
- FIFO:
  - out_valid = FIFO not empty.
  - out_data = head, combinational from storage.
  - A pop occurs on out_valid && out_ready; each pop increments count.
  - count saturates at 2^CW-1 and never wraps.
  - Write is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle (simultaneous push/pop keeps the occupancy unchanged).
  - A write while full without a pop drops the item and sets overflow. overflow stays set until the next start or reset.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is tracked separately with log2(DEPTH)+1 bits.
- Latency:
  - An item accepted in cycle t appears on out_data with out_valid=1 in cycle t+1 (FIFO was empty, nothing else ahead of it).
  - start in cycle t: en_read is high in cycle t+1.
- Empty list: in_done with no items goes STREAM → DRAIN → DONE. done pulses 2 cycles after in_done, with count=0.
- Downstream may hold out_ready low indefinitely; the block waits in DRAIN.
- Items stay in arrival order; the block performs no reordering.

Test Plan:
1. Reset, then start, then stream 3,1,2,0 on consecutive cycles with out_ready=1, then in_done → en_read pulse 1 cycle after start; out_data sequence 3,1,2,0; count=4; done pulse; overflow=0.
2. out_ready=0 while 6 items stream in, with DEPTH=4 → first 4 items kept, overflow=1. Then raise out_ready → 4 items delivered, count=4, done pulses.
3. FIFO full, with in_valid and out_ready both high in the same cycle → no drop, occupancy stays 4, overflow stays 0.
4. in_done in the first STREAM cycle with no items → done pulses 2 cycles later, count=0, out_valid is never high.
5. RST low mid-stream after 2 items → next cycle: busy=0, out_valid=0, count=0. A new start then proceeds normally.
6. start pulsed again during STREAM, and in_valid together with in_done on the last item → second start ignored (en_read does not pulse again), last item delivered.
